icache_refill_ctrl: RTL

ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

---
 rtl/cache_pkg.sv | 14 +
 rtl/refill_line_buffer.sv | 31 +++
 rtl/icache_refill_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache refill FSM states and AXI response codes
package cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_FILL  = 3'd3,
    ST_DRAIN = 3'd4
  } refill_state_e;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/refill_line_buffer.sv
// rtl/refill_line_buffer.sv - assembles AXI read beats into one cache line
module refill_line_buffer #(
  parameter int BLOCK_WIDTH    = 512,
  parameter int AXI_DATA_WIDTH = 64,
  localparam int BEATS         = BLOCK_WIDTH / AXI_DATA_WIDTH,
  localparam int CNT_W         = $clog2(BEATS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      beat_valid,
  input  logic [AXI_DATA_WIDTH-1:0] beat_data,
  output logic [CNT_W-1:0]          cnt,
  output logic [BLOCK_WIDTH-1:0]    block
);

  // The counter wraps naturally, so an over-long burst overwrites from slice 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      block <= '0;
    end else if (clear) begin
      cnt   <= '0;
      block <= '0;
    end else if (beat_valid) begin
      block[cnt*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= beat_data;
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - I-cache miss refill controller: AXI burst read, line fill, flush drain
// Defining ICACHE_REFILL_PERF_CNT_EN adds the saturating o_miss_count output.
module icache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH     = 64,
  parameter int BLOCK_WIDTH    = 512,
  parameter int AXI_DATA_WIDTH = 64
) (
  input  logic                      i_clk,
  input  logic                      i_arst,
  input  logic                      i_icache_hit,
  input  logic [ADDR_WIDTH-1:0]     i_fetch_addr,
  input  logic                      i_flush,
  output logic                      o_ar_valid,
  input  logic                      i_ar_ready,
  output logic [ADDR_WIDTH-1:0]     o_ar_addr,
  output logic [7:0]                o_ar_len,
  input  logic                      i_r_valid,
  output logic                      o_r_ready,
  input  logic [AXI_DATA_WIDTH-1:0] i_r_data,
  input  logic                      i_r_last,
  input  logic [1:0]                i_r_resp,
  output logic                      o_instr_we,
  output logic [BLOCK_WIDTH-1:0]    o_instr_block,
  output logic                      o_stall_fetch,
  output logic                      o_bus_error
`ifdef ICACHE_REFILL_PERF_CNT_EN
  ,
  output logic [31:0]               o_miss_count
`endif
);

  localparam int BEATS = BLOCK_WIDTH / AXI_DATA_WIDTH;
  localparam int CNT_W = $clog2(BEATS);

  refill_state_e         state, next_state;
  logic                  flush_pend;
  logic                  bus_error;
  logic                  latch_addr, clear_line, write_beat, set_err;
  logic [CNT_W-1:0]      cnt;
  logic                  last_slot;
  logic [ADDR_WIDTH-1:0] ar_addr;

  assign last_slot   = (cnt == CNT_W'(BEATS - 1));
  assign o_ar_len    = 8'(BEATS - 1);
  assign o_ar_addr   = ar_addr;
  assign o_bus_error = bus_error;

  // A flush seen while AR is still pending is remembered: the request cannot be withdrawn.
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      state      <= ST_IDLE;
      flush_pend <= 1'b0;
      ar_addr    <= '0;
      bus_error  <= 1'b0;
    end else begin
      state      <= next_state;
      flush_pend <= (state == ST_ADDR) && !i_ar_ready && (flush_pend || i_flush);
      if (latch_addr) ar_addr <= i_fetch_addr;
      if (set_err) bus_error <= 1'b1;
    end
  end

  always_comb begin
    next_state    = state;
    latch_addr    = 1'b0;
    clear_line    = 1'b0;
    write_beat    = 1'b0;
    set_err       = 1'b0;
    o_ar_valid    = 1'b0;
    o_r_ready     = 1'b0;
    o_instr_we    = 1'b0;
    o_stall_fetch = 1'b0;
    case (state)
      ST_IDLE: begin
        o_stall_fetch = !i_icache_hit;
        if (!i_icache_hit) begin
          latch_addr = 1'b1;
          next_state = ST_ADDR;
        end
      end
      ST_ADDR: begin
        o_stall_fetch = 1'b1;
        o_ar_valid    = 1'b1;
        if (i_ar_ready) begin
          clear_line = 1'b1;
          next_state = (flush_pend || i_flush) ? ST_DRAIN : ST_DATA;
        end
      end
      ST_DATA: begin
        o_stall_fetch = 1'b1;
        o_r_ready     = 1'b1;
        if (i_r_valid) begin
          write_beat = 1'b1;
          // Burst length must agree with the line: last exactly on the final slot.
          if (i_r_resp != AXI_RESP_OKAY || i_r_last != last_slot) set_err = 1'b1;
        end
        if (i_flush)
          next_state = (i_r_valid && i_r_last) ? ST_IDLE : ST_DRAIN;
        else if (i_r_valid && i_r_last)
          next_state = ST_FILL;
      end
      ST_FILL: begin
        o_stall_fetch = 1'b1;
        o_instr_we    = 1'b1;
        next_state    = ST_IDLE;
      end
      ST_DRAIN: begin
        o_r_ready = 1'b1;
        if (i_r_valid) begin
          if (i_r_resp != AXI_RESP_OKAY) set_err = 1'b1;
          if (i_r_last) next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  refill_line_buffer #(
    .BLOCK_WIDTH   (BLOCK_WIDTH),
    .AXI_DATA_WIDTH(AXI_DATA_WIDTH)
  ) u_line_buffer (
    .clk       (i_clk),
    .rst_n     (i_arst),
    .clear     (clear_line),
    .beat_valid(write_beat),
    .beat_data (i_r_data),
    .cnt       (cnt),
    .block     (o_instr_block)
  );

`ifdef ICACHE_REFILL_PERF_CNT_EN
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst)
      o_miss_count <= '0;
    else if (state == ST_ADDR && i_ar_ready && o_miss_count != 32'hFFFF_FFFF)
      o_miss_count <= o_miss_count + 32'd1;
  end
`endif

endmodule
